// File: rtl/ysyx_220053_pkg.sv
// Shared definitions for the ysyx_220053 fetch block: FSM states, reset PC and NOP encoding.
package ysyx_220053_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } ifu_state_e;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: one outstanding imem request, a holding latch toward decode,
// and redirect handling that can cancel a request already in flight.
module ysyx_220053_ifu
   import ysyx_220053_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_o_q, pc_o_d;
   logic [31:0]     instr_q, instr_d;
   logic            discard_q, discard_d;
   logic            misalign_q, misalign_d;
   logic            req_valid_q, req_valid_d;
   logic            instr_valid_q, instr_valid_d;
   logic            redir_take;

   // Redirects are only meaningful once fetching has started.
   assign redir_take = redirect_valid && (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_o_d     = pc_o_q;
      instr_d    = instr_q;
      discard_d  = discard_q;
      misalign_d = misalign_q;

      if (redir_take) begin
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
      end

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_req_ready) begin
               state_d   = S_WAIT;
               // An accepted request cancelled in the same cycle still owes a response.
               discard_d = redir_take;
            end
         end
         S_WAIT: begin
            if (redir_take) begin
               if (imem_resp_valid) begin
                  state_d   = S_REQ;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_resp_valid) begin
               if (discard_q) begin
                  state_d   = S_REQ;
                  discard_d = 1'b0;
               end else begin
                  state_d = S_HOLD;
                  instr_d = imem_resp_data;
                  pc_o_d  = pc_q;
               end
            end
         end
         S_HOLD: begin
            if (redir_take) begin
               state_d = S_REQ;
            end else if (instr_ready) begin
               state_d = S_REQ;
               pc_d    = pc_q + XLEN'(4);
            end
         end
         default: state_d = S_IDLE;
      endcase

      req_valid_d   = (state_d == S_REQ);
      instr_valid_d = (state_d == S_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         pc_o_q        <= '0;
         instr_q       <= NOP_INSTR;
         discard_q     <= 1'b0;
         misalign_q    <= 1'b0;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pc_o_q        <= pc_o_d;
         instr_q       <= instr_d;
         discard_q     <= discard_d;
         misalign_q    <= misalign_d;
         req_valid_q   <= req_valid_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign instr_valid    = instr_valid_q;
   assign instr_o        = instr_q;
   assign pc_o           = pc_o_q;
   assign misalign       = misalign_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for ysyx_220053_ifu with a transaction-level fetch model and a simple memory.
module tb_ysyx_220053_ifu;

   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_o;
   logic [63:0] pc_o;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        misalign;

   ysyx_220053_ifu dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_o(instr_o), .pc_o(pc_o),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] memf(input logic [63:0] a);
      return a[31:0] ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- fetch model ----------------
   logic [63:0] exp_pc    = RST_PC;
   logic        inflight  = 1'b0;
   logic        stale     = 1'b0;
   logic [63:0] infl_addr = '0;
   logic        have      = 1'b0;
   logic [63:0] cur_addr  = '0;
   logic [31:0] cur_data  = '0;
   logic        mis       = 1'b0;
   logic        post_rst  = 1'b1;
   logic        mfire     = 1'b0;
   logic [63:0] mfire_addr = '0;
   logic        m_r, m_f, m_s, m_c;
   logic [63:0] fire_log[$];
   logic [63:0] dlv_pc[$];
   logic [31:0] dlv_data[$];
   int          mem_lat = 1;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         exp_pc = RST_PC; inflight = 0; stale = 0; have = 0; mis = 0; post_rst = 1; mfire = 0;
      end else begin
         m_r = redirect_valid;
         m_f = imem_req_valid && imem_req_ready;
         m_s = imem_resp_valid;
         m_c = have && instr_ready;
         mfire = m_f;
         mfire_addr = imem_addr;
         post_rst = 0;
         if (m_f) begin
            fire_log.push_back(imem_addr);
            inflight = 1; infl_addr = exp_pc; stale = 0;
         end else if (m_s && inflight) begin
            inflight = 0;
            if (!stale && !m_r) begin
               have = 1; cur_addr = infl_addr; cur_data = memf(infl_addr);
            end
         end
         if (m_r) begin
            exp_pc = {redirect_pc[63:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) mis = 1;
            if (inflight) stale = 1;
            have = 0;
         end else if (m_c) begin
            dlv_pc.push_back(cur_addr);
            dlv_data.push_back(cur_data);
            exp_pc = exp_pc + 64'd4;
            have = 0;
         end
      end
   end

   // ---------------- compare process ----------------
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_misalign", misalign, 0);
         chk("rst_pc_o", pc_o, 0);
         chk("rst_instr_o", instr_o, NOP);
      end else begin
         chk("instr_valid", instr_valid, have);
         if (have) begin
            chk("pc_o", pc_o, cur_addr);
            chk("instr_o", instr_o, cur_data);
         end
         chk("misalign", misalign, mis);
         chk("req_valid", imem_req_valid, !have && !inflight && !post_rst);
         if (imem_req_valid) chk("imem_addr", imem_addr, exp_pc);
      end
   end

   // ---------------- memory ----------------
   logic        mpend = 1'b0;
   int          mcnt  = 0;
   logic [63:0] maddr = '0;

   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(posedge clk); #1;
         imem_resp_valid = 1'b0;
         if (mfire) begin mpend = 1; mcnt = mem_lat; maddr = mfire_addr; end
         if (mpend) begin
            mcnt--;
            if (mcnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = memf(maddr);
               mpend = 0;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_fire(input int n0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fire_log.size() > n0) return;
      end
      n_tests++; n_fail++;
      $display("FAIL wait_fire: request %0d not issued within 40 cycles", n0);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 40; i++) begin
         if (instr_valid) return;
         @(negedge clk);
      end
      n_tests++; n_fail++;
      $display("FAIL wait_valid: instr_valid not seen within 40 cycles");
   endtask

   task automatic wait_reqv();
      for (int i = 0; i < 40; i++) begin
         if (imem_req_valid) return;
         @(negedge clk);
      end
      n_tests++; n_fail++;
      $display("FAIL wait_reqv: imem_req_valid not seen within 40 cycles");
   endtask

   task automatic chk_fire(input string nm, input int idx, input logic [63:0] exp);
      if (idx < fire_log.size()) chk(nm, fire_log[idx], exp);
      else begin
         n_tests++; n_fail++;
         $display("FAIL %s: request %0d missing, expected addr %h", nm, idx, exp);
      end
   endtask

   task automatic pulse_redir(input logic [63:0] t);
      redirect_pc = t;
      redirect_valid = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;

      // sequential fetch, always-ready memory, 1-cycle response
      repeat (12) @(negedge clk);
      chk_fire("seq_addr0", 0, 64'h8000_0000);
      chk_fire("seq_addr1", 1, 64'h8000_0004);
      chk_fire("seq_addr2", 2, 64'h8000_0008);
      if (dlv_data.size() > 1) begin
         chk("seq_data0", dlv_data[0], 32'h5EAD_0000);
         chk("seq_pc1", dlv_pc[1], 64'h8000_0004);
      end else begin
         n_tests++; n_fail++;
         $display("FAIL seq_dlv: %0d deliveries, expected at least 2", dlv_data.size());
      end

      // decode stall for 5 cycles
      instr_ready = 1'b0;
      wait_valid();
      n = fire_log.size();
      repeat (5) @(negedge clk);
      chk("stall_no_req", fire_log.size() - n, 0);
      chk("stall_valid", instr_valid, 1);
      instr_ready = 1'b1;

      // redirect while waiting on memory: stale response dropped
      mem_lat = 3;
      n = fire_log.size();
      wait_fire(n);
      n = fire_log.size();
      pulse_redir(64'h8000_0100);
      wait_fire(n);
      chk_fire("wait_redir_addr", n, 64'h8000_0100);
      mem_lat = 1;

      // redirect coincident with instr_ready at pc 0x80000010
      instr_ready = 1'b0;
      pulse_redir(64'h8000_0010);
      wait_valid();
      chk("hold_pc", pc_o, 64'h8000_0010);
      chk("hold_instr", instr_o, 32'h5EAD_0010);
      n = fire_log.size();
      instr_ready = 1'b1;
      pulse_redir(64'h8000_0200);
      wait_fire(n);
      chk_fire("hold_redir_addr", n, 64'h8000_0200);

      // misaligned redirect
      wait_valid();
      n = fire_log.size();
      pulse_redir(64'h8000_0102);
      wait_fire(n);
      chk_fire("misalign_addr", n, 64'h8000_0100);
      chk("misalign_flag", misalign, 1);

      // redirect coincident with the response: no discard, straight back to REQ
      mem_lat = 2;
      n = fire_log.size();
      wait_fire(n);
      @(negedge clk);
      pulse_redir(64'h8000_0300);
      wait_fire(n + 1);
      chk_fire("coinc_redir_addr", n + 1, 64'h8000_0300);
      mem_lat = 1;

      // redirect while a request is stalled by memory
      imem_req_ready = 1'b0;
      n = fire_log.size();
      wait_reqv();
      pulse_redir(64'h8000_0400);
      imem_req_ready = 1'b1;
      wait_fire(n);
      chk_fire("req_redir_addr", n, 64'h8000_0400);

      // PC wraps modulo 2^64
      wait_valid();
      n = fire_log.size();
      pulse_redir(64'hFFFF_FFFF_FFFF_FFFC);
      wait_fire(n);
      chk_fire("wrap_top", n, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_fire(n + 1);
      chk_fire("wrap_zero", n + 1, 64'h0);

      // reset during WAIT with a late response afterwards
      mem_lat = 6;
      n = fire_log.size();
      wait_fire(n);
      @(posedge clk); #2;
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      mem_lat = 1;
      n = fire_log.size();
      imem_req_ready = 1'b1;
      wait_fire(n);
      chk_fire("rst_restart_addr", n, 64'h8000_0000);
      chk("rst_misalign_clr", misalign, 0);
      wait_valid();
      chk("rst_restart_pc", pc_o, 64'h8000_0000);
      chk("rst_restart_instr", instr_o, 32'h5EAD_0000);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_220053_ifu.md
YSYX_220053_IFU -- requirements
Module: ysyx_220053_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter XLEN, default 64, width of PC and redirect target.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-007 SHALL have port imem_addr, output, XLEN, fetch address, valid with imem_req_valid.
REQ-008 SHALL have port imem_resp_valid, input, 1, response data valid, one-cycle pulse.
REQ-009 SHALL have port imem_resp_data, input, 32, fetched instruction word.
REQ-010 SHALL have port instr_valid, output, 1, instr_o and pc_o hold a fetched instruction for decode.
REQ-011 SHALL have port instr_ready, input, 1, decode consumes the instruction.
REQ-012 SHALL have port instr_o, output, 32, instruction passed to the controller's instr_i.
REQ-013 SHALL have port pc_o, output, XLEN, PC of instr_o.
REQ-014 SHALL have port redirect_valid, input, 1, branch/jump taken, one-cycle pulse.
REQ-015 SHALL have port redirect_pc, input, XLEN, new fetch target.
REQ-016 SHALL have port misalign, output, 1, sticky flag: redirect target had bits [1:0] != 0.

Function
REQ-017 SHALL run FSM IDLE -> REQ -> WAIT -> HOLD -> REQ, one outstanding request at most.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then enter REQ.
REQ-019 REQ SHALL assert imem_req_valid with imem_addr=pc; on imem_req_ready, go to WAIT.
REQ-020 WAIT SHALL deassert imem_req_valid; on imem_resp_valid, latch data into instr_o, pc into pc_o, go to HOLD.
REQ-021 HOLD SHALL assert instr_valid; on instr_ready, set pc=pc+4 (modulo 2^XLEN) and go to REQ in the same edge.
REQ-022 instr_o and pc_o SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-023 Latency SHALL be: request issued the cycle after entering REQ; instr_valid the cycle after imem_resp_valid.
REQ-024 redirect_valid in REQ or HOLD SHALL set pc=redirect_pc, drop instr_valid, and enter REQ next cycle; a request accepted in the same REQ cycle is treated as in flight (REQ-025).
REQ-025 redirect_valid in WAIT SHALL set pc=redirect_pc and a discard flag; the next response SHALL be dropped, then the FSM SHALL go to REQ.
REQ-026 redirect_valid coincident with imem_resp_valid in WAIT SHALL drop that response and go to REQ directly, with no discard flag set.
REQ-027 redirect_valid coincident with instr_ready in HOLD: redirect SHALL win; pc=redirect_pc, not pc+4.
REQ-028 Misaligned redirect_pc SHALL set misalign, load pc with bits [1:0] cleared, and continue fetching.
REQ-029 imem_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-030 While rst_n=0: state=IDLE, pc=RESET_PC, discard=0, misalign=0, instr_o=32'h00000013 (NOP), pc_o=0, imem_req_valid=0, instr_valid=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; any response that arrives before the first new request SHALL be ignored.

Structure
REQ-032 The state enum, RESET_PC default, and NOP constant SHALL live in the shared ysyx_220053 package.
REQ-033 The block SHALL be a single module with no sub-modules; the pc register, FSM, and output latch sit inline.

Verification
REQ-034 Reset release, memory always ready, 1-cycle response -> first imem_addr=0x80000000, then 0x80000004, 0x80000008; instr_o matches the memory contents.
REQ-035 Decode holds instr_ready=0 for 5 cycles -> instr_valid, instr_o, and pc_o stay stable; no new imem_req_valid is issued.
REQ-036 redirect_pc=0x80000100 in WAIT -> the stale response is dropped and the next imem_addr is 0x80000100.
REQ-037 redirect coincident with instr_ready at pc 0x80000010 -> the next fetch is at the redirect target, not 0x80000014.
REQ-038 redirect_pc=0x80000102 -> misalign=1 and imem_addr=0x80000100.
REQ-039 rst_n low during WAIT, then a late response arrives -> the response is ignored and fetch restarts at 0x80000000.
